// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common -- basic fixed-width scalar types shared across the pipeline.
//   u64 : 64-bit word (addresses, PCs)
//   u32 : 32-bit word (instructions)
//   u1  : single-bit flag
// -----------------------------------------------------------------------------
package common;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
    typedef logic        u1;

endpackage : common

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline -- definitions shared by the pipeline stages.
//   fetch_state_t    : instruction-fetch FSM encoding
//   PC_RESET_DEFAULT : first fetch address after reset
// -----------------------------------------------------------------------------
package pipeline;

    import common::*;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // one quiet cycle after reset
        FETCH   = 2'd1,  // bus request for pc in flight
        DISCARD = 2'd2,  // finish an abandoned request, drop its data
        HOLD    = 2'd3   // instruction presented to decode
    } fetch_state_t;

    localparam u64 PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

endpackage : pipeline

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch -- instruction fetch stage.
//
// Issues one instruction-bus request per PC, holds the returned instruction
// until decode accepts it, then advances pc by 4. A redirect replaces pc at any
// point; a request already on the bus is always completed (its data dropped in
// DISCARD) so ireq_valid never retracts before iresp_ok. Misaligned PCs produce
// no bus request and are handed to decode with out_misaligned set.
//
// Ports
//   clk, reset          : clock (rising edge), async active-high reset
//   redirect, redirect_pc : flush and new fetch target
//   ireq_valid, ireq_addr : instruction-bus request
//   iresp_ok, iresp_data  : bus completion and returned instruction
//   out_valid, out_ready  : handshake with decode
//   out_pc, out_inst, out_misaligned : fetched instruction bundle
//   pcplus4             : pc + 4, for the external PC-select block
// -----------------------------------------------------------------------------
module ifetch
    import common::*;
    import pipeline::*;
#(
    parameter u64 PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_misaligned,
    output logic [63:0] pcplus4
);

    fetch_state_t state_q, state_d;
    u64           pc_q, pc_d;
    u64           req_addr_q, req_addr_d;
    u32           inst_q, inst_d;
    u1            misaligned_q, misaligned_d;

    logic aligned;

    assign aligned = (pc_q[1:0] == 2'b00);
    assign pcplus4 = pc_q + 64'd4;  // wraps modulo 2^64

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no
        // path through the case below can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        inst_d       = inst_q;
        misaligned_d = misaligned_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                // Remember the address on the bus in case a redirect forces
                // the request to be completed from DISCARD.
                if (aligned) begin
                    req_addr_d = pc_q;
                end
                if (redirect) begin
                    pc_d = redirect_pc;
                    // Only an outstanding, unanswered request needs DISCARD;
                    // a completed one (or none at all) restarts immediately.
                    if (aligned && !iresp_ok) begin
                        state_d = DISCARD;
                    end
                end else if (!aligned) begin
                    inst_d       = 32'h0;
                    misaligned_d = 1'b1;
                    state_d      = HOLD;
                end else if (iresp_ok) begin
                    inst_d       = iresp_data;
                    misaligned_d = 1'b0;
                    state_d      = HOLD;
                end
            end

            DISCARD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (iresp_ok) begin
                    state_d = FETCH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (out_ready) begin
                    pc_d    = pcplus4;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= PC_RESET;
            req_addr_q   <= '0;
            inst_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its neighbours.
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            inst_q       <= inst_d;
            misaligned_q <= misaligned_d;
        end
    end

    // In FETCH the request address is pc itself so the first request cycle
    // needs no extra register stage; DISCARD replays the captured address.
    assign ireq_valid     = ((state_q == FETCH) && aligned) || (state_q == DISCARD);
    assign ireq_addr      = (state_q == FETCH) ? pc_q : req_addr_q;

    assign out_valid      = (state_q == HOLD) && !redirect;
    assign out_pc         = pc_q;
    assign out_inst       = inst_q;
    assign out_misaligned = misaligned_q;

endmodule : ifetch

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch -- directed self-checking bench for ifetch.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misaligned;
    logic [63:0] pcplus4;

    int checks = 0;
    int errors = 0;

    ifetch #(.PC_RESET(PC_RST)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_ok       (iresp_ok),
        .iresp_data     (iresp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_misaligned (out_misaligned),
        .pcplus4        (pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Instruction word the bench's memory returns for a given address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    // Advance to the next falling edge (start of a new drive/sample slot).
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        iresp_ok = 1'b0; iresp_data = '0; out_ready = 1'b1;
        cyc(); cyc(); cyc(); #1;
        checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL reset_ireq_valid: got %b want 0", ireq_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (pcplus4 !== 64'h8000_0004) begin errors++; $display("FAIL reset_pcplus4: got %h want 80000004", pcplus4); end
        checks++; if (out_pc !== PC_RST) begin errors++; $display("FAIL reset_out_pc: got %h want %h", out_pc, PC_RST); end
        checks++; if (out_inst !== 32'h0 || out_misaligned !== 1'b0) begin errors++; $display("FAIL reset_inst: got %h/%b want 0/0", out_inst, out_misaligned); end
        cyc(); reset = 1'b0; #1;
        checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL idle_ireq_valid: got %b want 0", ireq_valid); end
    endtask

    // First two fetches with the response one cycle after the request.
    task automatic test_sequential();
        logic [63:0] a;
        for (int i = 0; i < 2; i++) begin
            a = PC_RST + 64'(4 * i);
            cyc(); iresp_ok = 1'b0; #1;
            checks++; if (ireq_valid !== 1'b1 || ireq_addr !== a) begin errors++; $display("FAIL seq_req%0d: got %b/%h want 1/%h", i, ireq_valid, ireq_addr, a); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_noout%0d: got %b want 0", i, out_valid); end
            cyc(); iresp_ok = 1'b1; iresp_data = mem_word(a); #1;
            checks++; if (ireq_valid !== 1'b1 || ireq_addr !== a) begin errors++; $display("FAIL seq_req_stable%0d: got %b/%h want 1/%h", i, ireq_valid, ireq_addr, a); end
            cyc(); iresp_ok = 1'b0; #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== a) begin errors++; $display("FAIL seq_out%0d: got %b/%h want 1/%h", i, out_valid, out_pc, a); end
            checks++; if (out_inst !== mem_word(a) || out_misaligned !== 1'b0) begin errors++; $display("FAIL seq_inst%0d: got %h/%b want %h/0", i, out_inst, out_misaligned, mem_word(a)); end
            checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL seq_hold_noreq%0d: got %b want 0", i, ireq_valid); end
        end
    endtask

    // Zero-wait memory: one instruction every two cycles (pc 0x..08 .. 0x..10).
    task automatic test_back_to_back();
        logic [63:0] a;
        for (int i = 0; i < 3; i++) begin
            a = PC_RST + 64'(8 + 4 * i);
            cyc(); iresp_ok = 1'b1; iresp_data = mem_word(a); #1;
            checks++; if (ireq_valid !== 1'b1 || ireq_addr !== a) begin errors++; $display("FAIL b2b_req%0d: got %b/%h want 1/%h", i, ireq_valid, ireq_addr, a); end
            cyc(); iresp_ok = 1'b0; #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== a || out_inst !== mem_word(a)) begin errors++; $display("FAIL b2b_out%0d: got %b/%h/%h want 1/%h/%h", i, out_valid, out_pc, out_inst, a, mem_word(a)); end
        end
    endtask

    // Redirect while the request for 0x..14 waits; its response comes 3 cycles later.
    task automatic test_redirect_discard();
        cyc(); redirect = 1'b1; redirect_pc = 64'h8000_0100; #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0014) begin errors++; $display("FAIL disc_req: got %b/%h want 1/80000014", ireq_valid, ireq_addr); end
        for (int i = 0; i < 2; i++) begin
            cyc(); redirect = 1'b0; #1;
            checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0014 || out_valid !== 1'b0) begin errors++; $display("FAIL disc_wait%0d: got %b/%h/%b want 1/80000014/0", i, ireq_valid, ireq_addr, out_valid); end
        end
        cyc(); iresp_ok = 1'b1; iresp_data = 32'hDEAD_BEEF; #1;
        checks++; if (ireq_addr !== 64'h8000_0014 || out_valid !== 1'b0) begin errors++; $display("FAIL disc_resp: got %h/%b want 80000014/0", ireq_addr, out_valid); end
        cyc(); iresp_ok = 1'b0; #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100 || out_valid !== 1'b0) begin errors++; $display("FAIL disc_newreq: got %b/%h/%b want 1/80000100/0", ireq_valid, ireq_addr, out_valid); end
        cyc(); iresp_ok = 1'b1; iresp_data = mem_word(64'h8000_0100); #1;
        cyc(); iresp_ok = 1'b0; #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100 || out_inst !== mem_word(64'h8000_0100)) begin errors++; $display("FAIL disc_out: got %b/%h/%h want 1/80000100/%h", out_valid, out_pc, out_inst, mem_word(64'h8000_0100)); end
    endtask

    // A second redirect inside DISCARD only retargets pc (fetch at 0x..104).
    task automatic test_discard_reredirect();
        cyc(); redirect = 1'b1; redirect_pc = 64'h8000_0300; #1;
        cyc(); redirect_pc = 64'h8000_0400; #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0104) begin errors++; $display("FAIL redisc_req: got %b/%h want 1/80000104", ireq_valid, ireq_addr); end
        cyc(); redirect = 1'b0; iresp_ok = 1'b1; iresp_data = 32'h1111_2222; #1;
        checks++; if (ireq_addr !== 64'h8000_0104 || out_valid !== 1'b0) begin errors++; $display("FAIL redisc_resp: got %h/%b want 80000104/0", ireq_addr, out_valid); end
        cyc(); iresp_data = mem_word(64'h8000_0400); #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0400) begin errors++; $display("FAIL redisc_newreq: got %b/%h want 1/80000400", ireq_valid, ireq_addr); end
        cyc(); iresp_ok = 1'b0; #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0400) begin errors++; $display("FAIL redisc_out: got %b/%h want 1/80000400", out_valid, out_pc); end
    endtask

    // Redirect and response in the same FETCH cycle (fetch at 0x..404).
    task automatic test_redirect_same_cycle();
        cyc(); redirect = 1'b1; redirect_pc = 64'h8000_0500; iresp_ok = 1'b1; iresp_data = 32'h3333_4444; #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0404 || out_valid !== 1'b0) begin errors++; $display("FAIL same_req: got %b/%h/%b want 1/80000404/0", ireq_valid, ireq_addr, out_valid); end
        cyc(); redirect = 1'b0; iresp_ok = 1'b0; #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0500 || out_valid !== 1'b0) begin errors++; $display("FAIL same_newreq: got %b/%h/%b want 1/80000500/0", ireq_valid, ireq_addr, out_valid); end
    endtask

    // Decode stalls for 5 cycles on the instruction at 0x..500.
    task automatic test_hold_stall();
        cyc(); iresp_ok = 1'b1; iresp_data = mem_word(64'h8000_0500); out_ready = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            cyc(); iresp_ok = 1'b0; #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0500 || out_inst !== mem_word(64'h8000_0500) || ireq_valid !== 1'b0) begin errors++; $display("FAIL stall%0d: got v=%b pc=%h inst=%h req=%b", i, out_valid, out_pc, out_inst, ireq_valid); end
        end
        cyc(); out_ready = 1'b1; #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", out_valid); end
        cyc(); #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0504 || pcplus4 !== 64'h8000_0508) begin errors++; $display("FAIL stall_advance: got %b/%h/%h want 1/80000504/80000508", ireq_valid, ireq_addr, pcplus4); end
    endtask

    // Redirect in HOLD to a misaligned target.
    task automatic test_misaligned();
        cyc(); iresp_ok = 1'b1; iresp_data = mem_word(64'h8000_0504); out_ready = 1'b0; #1;
        cyc(); iresp_ok = 1'b0; redirect = 1'b1; redirect_pc = 64'h8000_0002; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_redirect_mask: got %b want 0", out_valid); end
        cyc(); redirect = 1'b0; #1;
        checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL mis_noreq: got %b want 0", ireq_valid); end
        cyc(); #1;
        checks++; if (out_valid !== 1'b1 || out_misaligned !== 1'b1 || out_inst !== 32'h0 || out_pc !== 64'h8000_0002) begin errors++; $display("FAIL mis_out: got %b/%b/%h/%h want 1/1/0/80000002", out_valid, out_misaligned, out_inst, out_pc); end
        checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL mis_hold_noreq: got %b want 0", ireq_valid); end
    endtask

    // pc + 4 wraps to zero at the top of the address space.
    task automatic test_wrap();
        cyc(); redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
        cyc(); redirect = 1'b0; iresp_ok = 1'b1; iresp_data = mem_word(64'hFFFF_FFFF_FFFF_FFFC); #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC || pcplus4 !== 64'h0) begin errors++; $display("FAIL wrap_req: got %b/%h/%h want 1/fffffffffffffffc/0", ireq_valid, ireq_addr, pcplus4); end
        cyc(); iresp_ok = 1'b0; out_ready = 1'b1; #1;
        checks++; if (out_valid !== 1'b1 || out_misaligned !== 1'b0 || out_inst !== mem_word(64'hFFFF_FFFF_FFFF_FFFC)) begin errors++; $display("FAIL wrap_out: got %b/%b/%h", out_valid, out_misaligned, out_inst); end
        cyc(); #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0) begin errors++; $display("FAIL wrap_next: got %b/%h want 1/0", ireq_valid, ireq_addr); end
    endtask

    // Reset arriving mid-cycle while a DISCARD request is outstanding.
    task automatic test_reset_in_discard();
        cyc(); redirect = 1'b1; redirect_pc = 64'h8000_0600; #1;
        cyc(); redirect = 1'b0; #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0) begin errors++; $display("FAIL rstd_discard: got %b/%h want 1/0", ireq_valid, ireq_addr); end
        #1; reset = 1'b1; #1;
        checks++; if (ireq_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstd_async: got %b/%b want 0/0", ireq_valid, out_valid); end
        checks++; if (pcplus4 !== 64'h8000_0004) begin errors++; $display("FAIL rstd_pcplus4: got %h want 80000004", pcplus4); end
        cyc(); reset = 1'b0; #1;
        checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL rstd_idle: got %b want 0", ireq_valid); end
        cyc(); #1;
        checks++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST) begin errors++; $display("FAIL rstd_restart: got %b/%h want 1/%h", ireq_valid, ireq_addr, PC_RST); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_back_to_back();
        test_redirect_discard();
        test_discard_reredirect();
        test_redirect_same_cycle();
        test_hold_stall();
        test_misaligned();
        test_wrap();
        test_reset_in_discard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ifetch

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: PC_RESET, 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: redirect  in  1  flush; next fetch from redirect_pc (jump/exception/mret resolved upstream).
REQ-005 Port: redirect_pc  in  64  selected target address.
REQ-006 Port: ireq_valid  out  1  instruction-bus request valid.
REQ-007 Port: ireq_addr  out  64  instruction-bus request address.
REQ-008 Port: iresp_ok  in  1  request accepted and data returned; may assert in the same cycle as ireq_valid.
REQ-009 Port: iresp_data  in  32  fetched instruction, valid with iresp_ok.
REQ-010 Port: out_valid  out  1  instruction available to decode.
REQ-011 Port: out_ready  in  1  decode accepts this cycle.
REQ-012 Port: out_pc, out_inst, out_misaligned  out  64/32/1  fetched PC, instruction, misaligned-fetch flag.
REQ-013 Port: pcplus4  out  64  current pc register + 4, feeding PC selection.

Function
REQ-014 FSM states: IDLE, FETCH, DISCARD, HOLD; pc register (64), req_addr register (64), inst register (32), misaligned flag register.
REQ-015 IDLE: outputs idle; next cycle -> FETCH.
REQ-016 FETCH entry with pc[1:0]==0: ireq_valid=1, ireq_addr=req_addr=pc, held stable until iresp_ok.
REQ-017 FETCH with pc[1:0]!=0: no bus request; -> HOLD with inst=32'h0, misaligned=1.
REQ-018 FETCH, iresp_ok, no redirect: capture iresp_data, misaligned=0 -> HOLD.
REQ-019 FETCH, redirect, no iresp_ok: pc<=redirect_pc -> DISCARD; request continues at old req_addr.
REQ-020 FETCH, redirect and iresp_ok same cycle: drop data, pc<=redirect_pc, remain FETCH; new request from next cycle.
REQ-021 DISCARD: ireq_valid=1 at req_addr, out_valid=0; on iresp_ok drop data -> FETCH; further redirect only updates pc.
REQ-022 HOLD: out_valid = !redirect; out_pc=pc, out_inst/out_misaligned from registers.
REQ-023 HOLD, out_ready, no redirect: pc<=pc+4 -> FETCH.
REQ-024 HOLD, redirect (regardless of out_ready): pc<=redirect_pc -> FETCH; held instruction discarded.
REQ-025 HOLD, !out_ready, no redirect: all state and outputs unchanged.
REQ-026 pc+4 wraps modulo 2^64; no overflow detection.
REQ-027 Zero-wait memory throughput: one instruction per 2 cycles.
REQ-028 ireq_valid never deasserts before iresp_ok once asserted, except on reset.

Reset
REQ-029 On reset assertion, immediately: state=IDLE, pc=PC_RESET, req_addr=0, inst=0, misaligned=0.
REQ-030 During reset: ireq_valid=0, out_valid=0, pcplus4=PC_RESET+4.
REQ-031 Reset mid-request abandons the transaction; bus must tolerate an unanswered request after reset.

Structure
REQ-032 fetch_state_t enum and PC_RESET default value defined in package pipeline; u64/u32/u1 from common.
REQ-033 Single flat module; no sub-module; PC selection stays a separate external block.

Verification
REQ-034 Reset, out_ready=1, iresp_ok in the cycle after ireq_valid -> first ireq_addr=0x80000000, out_pc 0x80000000 then 0x80000004.
REQ-035 Redirect to 0x80000100 in FETCH with iresp_ok delayed 3 cycles -> DISCARD, old data dropped, next ireq_addr=0x80000100, no out_valid for the old PC.
REQ-036 Redirect and iresp_ok same cycle in FETCH -> no out_valid, next ireq_addr=redirect_pc.
REQ-037 HOLD with out_ready=0 for 5 cycles -> out_pc/out_inst stable, no bus request; out_ready=1 -> pc advances by 4.
REQ-038 Redirect to 0x80000002 -> no bus request, out_valid=1, out_misaligned=1, out_inst=0, out_pc=0x80000002.
REQ-039 Reset asserted while in DISCARD -> ireq_valid drops immediately; restart at PC_RESET.
